// File: rtl/me_pkg.sv
// Shared definitions for the modular-exponentiation job dispatcher:
// slot geometry, FSM encoding and operand-width helpers.
package me_pkg;

   // Four launch slots, addressed by a 2-bit id (presented on a 4-bit port).
   localparam int SLOT_N = 4;
   localparam int SLOT_W = 2;
   localparam int NUM_W  = 4;

   // Default core geometry.
   localparam int DEF_M_SIZE   = 3072;
   localparam int DEF_RADIX    = 72;
   localparam int DEF_SIZE_LOG = 6;
   localparam int DEF_MN_W     = DEF_M_SIZE + 2;
   localparam int DEF_MP_W     = DEF_RADIX + DEF_SIZE_LOG + 2;

   // Launch sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_WAIT = 2'd2,
      ST_GO   = 2'd3
   } state_t;

   // Width of the modulus-multiple operand for a given operand width.
   function automatic int mn_width(input int m_size);
      return m_size + 2;
   endfunction

   // Width of the Montgomery constant for a given digit and log width.
   function automatic int mp_width(input int radix, input int size_log);
      return radix + size_log + 2;
   endfunction

endpackage

// File: rtl/me_job_dispatcher_slot_alloc.sv
// Lowest-free slot picker over the 4-bit occupancy bitmap.
module slot_alloc
   import me_pkg::*;
(
   input  logic [SLOT_N-1:0] i_busy,
   output logic [SLOT_W-1:0] o_slot,
   output logic              o_full
);

   // Priority encode the first clear bit, slot 0 winning.
   always_comb begin
      o_slot = 2'd0;
      if (!i_busy[0]) begin
         o_slot = 2'd0;
      end else if (!i_busy[1]) begin
         o_slot = 2'd1;
      end else if (!i_busy[2]) begin
         o_slot = 2'd2;
      end else begin
         o_slot = 2'd3;
      end
   end

   // No slot available when every bit is set.
   always_comb begin
      o_full = &i_busy;
   end

endmodule

// File: rtl/me_job_dispatcher.sv
// Front end for the modular-exponentiation core: accepts jobs, allocates a
// slot, sequences en_pre_me / en_me (or en_one_mm), and returns results
// through a one-deep valid/ready register with per-slot tags.
module me_job_dispatcher
   import me_pkg::*;
#(
   parameter int M_SIZE   = DEF_M_SIZE,
   parameter int RADIX    = DEF_RADIX,
   parameter int SIZE_LOG = DEF_SIZE_LOG,
   parameter int TAG_W    = 8,
   parameter int PRE_WAIT = 4
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        job_valid,
   output logic                        job_ready,
   input  logic                        job_one_mm,
   input  logic [TAG_W-1:0]            job_tag,
   input  logic [M_SIZE-1:0]           job_a,
   input  logic [M_SIZE-1:0]           job_e,
   input  logic [M_SIZE-1:0]           job_m,
   input  logic [M_SIZE+1:0]           job_m_n,
   input  logic [RADIX+SIZE_LOG+1:0]   job_m_prime,
   output logic                        en_pre_me,
   output logic                        en_me,
   output logic                        en_one_mm,
   output logic [3:0]                  num,
   output logic [M_SIZE-1:0]           a,
   output logic [M_SIZE-1:0]           e,
   output logic [M_SIZE-1:0]           m,
   output logic [M_SIZE+1:0]           m_n,
   output logic [RADIX+SIZE_LOG+1:0]   m_prime,
   input  logic [M_SIZE-1:0]           z,
   input  logic [3:0]                  num_out,
   input  logic                        done,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [M_SIZE-1:0]           res_z,
   output logic [TAG_W-1:0]            res_tag,
   output logic [3:0]                  busy_slots,
   output logic [1:0]                  err
);

   localparam int MN_W  = mn_width(M_SIZE);
   localparam int MP_W  = mp_width(RADIX, SIZE_LOG);
   localparam int CNT_W = (PRE_WAIT > 1) ? $clog2(PRE_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PRE_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Sequencer and launch registers
   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [SLOT_W-1:0]   r_slot;
   logic                r_one_mm;
   logic [M_SIZE-1:0]   r_a;
   logic [M_SIZE-1:0]   r_e;
   logic [M_SIZE-1:0]   r_m;
   logic [MN_W-1:0]     r_m_n;
   logic [MP_W-1:0]     r_m_prime;
   logic                r_en_pre_me;
   logic                r_en_me;
   logic                r_en_one_mm;
   logic                r_job_ready;

   // Occupancy, tags, results, errors
   logic [SLOT_N-1:0]   r_busy;
   logic [TAG_W-1:0]    r_tag_tbl [SLOT_N];
   logic                r_res_valid;
   logic [M_SIZE-1:0]   r_res_z;
   logic [TAG_W-1:0]    r_res_tag;
   logic [1:0]          r_err;

   // Combinational helpers
   logic [SLOT_W-1:0]   w_free_slot;
   logic                w_full;
   logic                w_accept;
   logic [SLOT_W-1:0]   w_done_k;
   logic                w_done_hit;
   logic                w_done_miss;
   logic                w_drain;
   logic                w_res_load;
   logic                w_res_drop;
   logic [SLOT_N-1:0]   w_clr_mask;
   logic [SLOT_N-1:0]   w_set_mask;
   logic [SLOT_N-1:0]   w_busy_next;
   logic                w_pre_pulse;
   logic                w_me_pulse;
   logic                w_one_pulse;
   logic                w_ready_next;
   logic                w_unused_num_hi;

   // Allocation looks at the registered bitmap only, so a slot freed by a
   // coincident done is not reusable until the following cycle.
   slot_alloc u_slot_alloc (
      .i_busy (r_busy),
      .o_slot (w_free_slot),
      .o_full (w_full)
   );

   // Core only ever reports slots 0..3; the upper id bits carry no meaning.
   assign w_unused_num_hi = |num_out[3:2];

   // Handshake and completion decode.
   always_comb begin
      w_accept    = job_valid && r_job_ready && !w_full;
      w_done_k    = num_out[SLOT_W-1:0];
      w_done_hit  = done && r_busy[w_done_k];
      w_done_miss = done && !r_busy[w_done_k];
      w_drain     = r_res_valid && res_ready;
      w_res_load  = w_done_hit && (!r_res_valid || w_drain);
      w_res_drop  = w_done_hit && !w_res_load;
   end

   // Next occupancy: completion clears its slot, an accept sets the new one.
   always_comb begin
      w_clr_mask = 4'b0000;
      w_set_mask = 4'b0000;
      if (w_done_hit) begin
         w_clr_mask[w_done_k] = 1'b1;
      end else begin
         w_clr_mask = 4'b0000;
      end
      if (w_accept) begin
         w_set_mask[w_free_slot] = 1'b1;
      end else begin
         w_set_mask = 4'b0000;
      end
      w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Sequencer next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_PRE;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (r_one_mm) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == CNT_ZERO) begin
               w_next_state = ST_GO;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_GO: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Sequencer outputs, decoded one cycle early so they can be registered.
   always_comb begin
      w_pre_pulse  = w_accept && !job_one_mm;
      w_one_pulse  = w_accept && job_one_mm;
      w_me_pulse   = (w_next_state == ST_GO);
      w_ready_next = (w_next_state == ST_IDLE) && (w_busy_next != 4'hF);
   end

   // Idle-gap counter between en_pre_me and en_me.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= CNT_ZERO;
      end else if (r_state == ST_PRE) begin
         r_cnt <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != CNT_ZERO)) begin
         r_cnt <= r_cnt - CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Capture operands and slot on accept; held stable until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= {M_SIZE{1'b0}};
         r_e       <= {M_SIZE{1'b0}};
         r_m       <= {M_SIZE{1'b0}};
         r_m_n     <= {MN_W{1'b0}};
         r_m_prime <= {MP_W{1'b0}};
         r_slot    <= 2'd0;
         r_one_mm  <= 1'b0;
      end else if (w_accept) begin
         r_a       <= job_a;
         r_e       <= job_e;
         r_m       <= job_m;
         r_m_n     <= job_m_n;
         r_m_prime <= job_m_prime;
         r_slot    <= w_free_slot;
         r_one_mm  <= job_one_mm;
      end else begin
         r_a       <= r_a;
         r_e       <= r_e;
         r_m       <= r_m;
         r_m_n     <= r_m_n;
         r_m_prime <= r_m_prime;
         r_slot    <= r_slot;
         r_one_mm  <= r_one_mm;
      end
   end

   // Per-slot user tag, written when the slot is allocated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOT_N; i++) begin
            r_tag_tbl[i] <= {TAG_W{1'b0}};
         end
      end else if (w_accept) begin
         r_tag_tbl[w_free_slot] <= job_tag;
      end else begin
         r_tag_tbl <= r_tag_tbl;
      end
   end

   // Slot occupancy bitmap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 4'b0000;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   // One-deep result register; a reload wins over a same-cycle drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_z     <= {M_SIZE{1'b0}};
         r_res_tag   <= {TAG_W{1'b0}};
      end else if (w_res_load) begin
         r_res_valid <= 1'b1;
         r_res_z     <= z;
         r_res_tag   <= r_tag_tbl[w_done_k];
      end else if (w_drain) begin
         r_res_valid <= 1'b0;
         r_res_z     <= r_res_z;
         r_res_tag   <= r_res_tag;
      end else begin
         r_res_valid <= r_res_valid;
         r_res_z     <= r_res_z;
         r_res_tag   <= r_res_tag;
      end
   end

   // Sticky error flags: bit0 dropped result, bit1 done for an idle slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 2'b00;
      end else begin
         r_err <= r_err | {w_done_miss, w_res_drop};
      end
   end

   // Registered launch pulses and job_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_pre_me <= 1'b0;
         r_en_me     <= 1'b0;
         r_en_one_mm <= 1'b0;
         r_job_ready <= 1'b0;
      end else begin
         r_en_pre_me <= w_pre_pulse;
         r_en_me     <= w_me_pulse;
         r_en_one_mm <= w_one_pulse;
         r_job_ready <= w_ready_next;
      end
   end

   assign job_ready  = r_job_ready;
   assign en_pre_me  = r_en_pre_me;
   assign en_me      = r_en_me;
   assign en_one_mm  = r_en_one_mm;
   assign num        = {2'b00, r_slot};
   assign a          = r_a;
   assign e          = r_e;
   assign m          = r_m;
   assign m_n        = r_m_n;
   assign m_prime    = r_m_prime;
   assign res_valid  = r_res_valid;
   assign res_z      = r_res_z;
   assign res_tag    = r_res_tag;
   assign busy_slots = r_busy;
   assign err        = r_err;

endmodule

// File: tb/tb_me_job_dispatcher.sv
// Randomized scoreboard bench for me_job_dispatcher with a slot-level model.
module tb_me_job_dispatcher;

   localparam int M_SIZE   = 64;
   localparam int RADIX    = 8;
   localparam int SIZE_LOG = 6;
   localparam int TAG_W    = 8;
   localparam int PRE_WAIT = 4;
   localparam int MN_W     = M_SIZE + 2;
   localparam int MP_W     = RADIX + SIZE_LOG + 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                job_valid = 1'b0;
   logic                job_ready;
   logic                job_one_mm = 1'b0;
   logic [TAG_W-1:0]    job_tag = '0;
   logic [M_SIZE-1:0]   job_a = '0, job_e = '0, job_m = '0;
   logic [MN_W-1:0]     job_m_n = '0;
   logic [MP_W-1:0]     job_m_prime = '0;
   logic                en_pre_me, en_me, en_one_mm;
   logic [3:0]          num;
   logic [M_SIZE-1:0]   a, e, m;
   logic [MN_W-1:0]     m_n;
   logic [MP_W-1:0]     m_prime;
   logic [M_SIZE-1:0]   z = '0;
   logic [3:0]          num_out = '0;
   logic                done = 1'b0;
   logic                res_valid;
   logic                res_ready = 1'b0;
   logic [M_SIZE-1:0]   res_z;
   logic [TAG_W-1:0]    res_tag;
   logic [3:0]          busy_slots;
   logic [1:0]          err;

   me_job_dispatcher #(
      .M_SIZE(M_SIZE), .RADIX(RADIX), .SIZE_LOG(SIZE_LOG),
      .TAG_W(TAG_W), .PRE_WAIT(PRE_WAIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_one_mm(job_one_mm),
      .job_tag(job_tag), .job_a(job_a), .job_e(job_e), .job_m(job_m),
      .job_m_n(job_m_n), .job_m_prime(job_m_prime),
      .en_pre_me(en_pre_me), .en_me(en_me), .en_one_mm(en_one_mm), .num(num),
      .a(a), .e(e), .m(m), .m_n(m_n), .m_prime(m_prime),
      .z(z), .num_out(num_out), .done(done),
      .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
      .res_tag(res_tag), .busy_slots(busy_slots), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected launches (kind 0 = en_pre_me, 1 = en_one_mm, 2 = en_me) and results
   typedef struct {
      int                kind;
      int                slot;
      int                edge_no;
      logic [M_SIZE-1:0] a, e, m;
      logic [MN_W-1:0]   mn;
      logic [MP_W-1:0]   mp;
   } launch_t;
   typedef struct {
      logic [M_SIZE-1:0] z;
      logic [TAG_W-1:0]  tag;
   } res_t;
   launch_t lq[$];
   res_t    rq[$];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model state
   bit [3:0]          m_busy = 4'b0000;
   logic [TAG_W-1:0]  m_tag [4];
   bit                m_res_valid = 1'b0;
   bit [1:0]          m_err = 2'b00;
   int                m_free_edge = 0;

   function automatic bit model_ready();
      return (cyc + 1 >= m_free_edge) && (m_busy != 4'hF);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares DUT outputs against the model and scoreboard queues.
   int      mon_n;
   int      mon_kind;
   launch_t mon_l;
   always @(negedge clk) begin
      if (chk_en) begin
         check("job_ready", job_ready, model_ready());
         check("busy_slots", busy_slots, m_busy);
         check("err", err, m_err);
         check("res_valid", res_valid, m_res_valid);
         if (res_valid && rq.size() > 0) begin
            check("res_z", res_z, rq[0].z);
            check("res_tag", res_tag, rq[0].tag);
         end
         mon_n = int'(en_pre_me) + int'(en_one_mm) + int'(en_me);
         if (mon_n > 0) begin
            check("pulse_count", mon_n, 1);
            mon_kind = en_pre_me ? 0 : (en_one_mm ? 1 : 2);
            if (lq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL launch_unexpected: got kind %0d expected none (edge %0d)", mon_kind, cyc + 1);
            end else begin
               mon_l = lq.pop_front();
               check("launch_kind", mon_kind, mon_l.kind);
               check("launch_edge", cyc + 1, mon_l.edge_no);
               check("launch_num", num, mon_l.slot);
               check("launch_a", a, mon_l.a);
               check("launch_e", e, mon_l.e);
               check("launch_m", m, mon_l.m);
               check("launch_m_n", m_n, mon_l.mn);
               check("launch_m_prime", m_prime, mon_l.mp);
            end
         end
      end
   end

   // One clock of stimulus; the model advances with the same inputs.
   task automatic step(input bit jv, input bit one, input logic [TAG_W-1:0] tg,
                       input bit dn, input logic [3:0] no, input logic [M_SIZE-1:0] zz,
                       input bit rr, output bit acc);
      bit [3:0]    old_busy;
      int          s;
      int          k;
      int          edge_e;
      launch_t     l;
      res_t        r;
      logic [95:0] t96;
      acc    = jv && model_ready();
      edge_e = cyc + 1;
      job_valid  = jv;
      job_one_mm = one;
      job_tag    = tg;
      job_a      = {$urandom(), $urandom()};
      job_e      = {$urandom(), $urandom()};
      job_m      = {$urandom(), $urandom()};
      t96        = {$urandom(), $urandom(), $urandom()};
      job_m_n    = t96[MN_W-1:0];
      job_m_prime = t96[MP_W-1:0] ^ 16'($urandom());
      done      = dn;
      num_out   = no;
      z         = zz;
      res_ready = rr;
      old_busy  = m_busy;
      if (m_res_valid && rr) begin
         void'(rq.pop_front());
         m_res_valid = 1'b0;
      end
      if (dn) begin
         k = int'(no[1:0]);
         if (old_busy[k]) begin
            m_busy[k] = 1'b0;
            if (!m_res_valid) begin
               r.z = zz;
               r.tag = m_tag[k];
               rq.push_back(r);
               m_res_valid = 1'b1;
            end else begin
               m_err[0] = 1'b1;
            end
         end else begin
            m_err[1] = 1'b1;
         end
      end
      if (acc) begin
         s = -1;
         for (int i = 3; i >= 0; i--) if (!old_busy[i]) s = i;
         m_tag[s]  = tg;
         m_busy[s] = 1'b1;
         l.slot = s; l.a = job_a; l.e = job_e; l.m = job_m;
         l.mn = job_m_n; l.mp = job_m_prime;
         l.kind = one ? 1 : 0;
         l.edge_no = edge_e + 1;
         lq.push_back(l);
         if (!one) begin
            l.kind = 2;
            l.edge_no = edge_e + PRE_WAIT + 2;
            lq.push_back(l);
         end
         m_free_edge = edge_e + (one ? 2 : PRE_WAIT + 3);
      end
      @(posedge clk);
      @(negedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 64'h0, 1'b1, acc);
   endtask

   task automatic do_done(input logic [3:0] no, input logic [M_SIZE-1:0] zz, input bit rr);
      bit acc;
      step(1'b0, 1'b0, 8'h00, 1'b1, no, zz, rr, acc);
   endtask

   task automatic offer(input bit one, input logic [TAG_W-1:0] tg);
      bit acc;
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (model_ready()) begin
            step(1'b1, one, tg, 1'b0, 4'h0, 64'h0, 1'b1, acc);
            got = acc;
         end else begin
            step(1'b0, one, tg, 1'b0, 4'h0, 64'h0, 1'b1, acc);
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL offer_timeout: got no accept expected accept for tag %0h", tg);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      chk_en = 1'b0;
      job_valid = 1'b0; done = 1'b0; res_ready = 1'b0;
      m_busy = 4'b0000; m_res_valid = 1'b0; m_err = 2'b00;
      for (int i = 0; i < 4; i++) m_tag[i] = '0;
      lq.delete();
      rq.delete();
      repeat (2) @(negedge clk);
      check("rst_job_ready", job_ready, 1'b0);
      check("rst_busy", busy_slots, 4'b0000);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_err", err, 2'b00);
      check("rst_pulses", {en_pre_me, en_me, en_one_mm}, 3'b000);
      check("rst_num", num, 4'h0);
      check("rst_ops", {a, e, m}, '0);
      check("rst_mn_mp", {m_n, m_prime}, '0);
      check("rst_res", {res_z, res_tag}, '0);
      #2;
      rst_n = 1'b1;
      m_free_edge = cyc + 2;
      #1;
      check("ready_at_release", job_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      #2;
   endtask

   initial begin
      bit acc;
      do_reset();

      // Single job, tag 0x11, lands in slot 0
      offer(1'b0, 8'h11);
      check("tp1_en_pre_me", en_pre_me, 1'b1);
      check("tp1_num_pre", num, 4'h0);
      idle(5);
      check("tp1_en_me", en_me, 1'b1);
      check("tp1_num_me", num, 4'h0);
      check("tp1_busy", busy_slots, 4'b0001);
      do_done(4'h0, 64'h1234, 1'b1);
      idle(2);

      // Fill all four slots, then a fifth waits until a done frees one
      for (int i = 0; i < 4; i++) offer(1'b0, 8'h20 + 8'(i));
      idle(8);
      repeat (10) step(1'b1, 1'b0, 8'h25, 1'b0, 4'h0, 64'h0, 1'b1, acc);
      check("tp2_full", busy_slots, 4'hF);
      step(1'b1, 1'b0, 8'h25, 1'b1, 4'h2, 64'hABC, 1'b0, acc);
      check("tp3_res_valid", res_valid, 1'b1);
      check("tp3_res_z", res_z, 64'hABC);
      check("tp3_res_tag", res_tag, 8'h22);
      check("tp3_busy", busy_slots, 4'b1011);
      offer(1'b0, 8'h25);
      idle(8);

      // Held result: second done is dropped and flags err[0]
      do_done(4'h0, 64'h1, 1'b0);
      do_done(4'h1, 64'h2, 1'b0);
      check("tp4_err", err, 2'b01);
      check("tp4_res_z", res_z, 64'h1);
      check("tp4_busy", busy_slots, 4'b1100);
      idle(2);

      // Done for an empty slot
      do_done(4'h0, 64'h3, 1'b1);
      check("tp5_err", err, 2'b11);
      check("tp5_busy", busy_slots, 4'b1100);

      // Back-to-back one_mm jobs
      offer(1'b1, 8'h51);
      check("tp6_en_one_mm", en_one_mm, 1'b1);
      check("tp6_no_pre", en_pre_me, 1'b0);
      check("tp6_ready_low", job_ready, 1'b0);
      offer(1'b1, 8'h52);
      idle(3);
      for (int i = 0; i < 4; i++) do_done(4'(i), 64'(i + 100), 1'b1);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              8'($urandom()), ($urandom_range(0, 3) == 0), 4'($urandom()),
              {$urandom(), $urandom()}, ($urandom_range(0, 2) != 0), acc);
      end
      idle(12);
      for (int i = 0; i < 4; i++) do_done(4'(i), 64'(i + 200), 1'b1);
      idle(3);

      // Reset during the pre-launch wait abandons the job
      offer(1'b0, 8'h77);
      idle(2);
      do_reset();
      idle(10);

      check("launch_queue_empty", lq.size(), 0);
      check("result_queue_empty", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/me_job_dispatcher.md
# me_job_dispatcher

Upstream front end for the modular-exponentiation core. It accepts exponentiation jobs over a valid/ready stream and assigns each one to one of four free slots (`num` 0..3). It drives the core's `en_pre_me`/`en_me` launch sequence with stable operands, then collects `z` on `done`/`num_out` into a one-deep result register with a valid/ready output. It also tracks slot occupancy and the user tag per slot.

## Interface
Parameters:
- M_SIZE, 3072, operand width
- RADIX, 72, digit width
- SIZE_LOG, 6, log term of m_prime width
- TAG_W, 8, user job tag width
- PRE_WAIT, 4, idle cycles between en_pre_me and en_me (≥1)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when job_valid && job_ready
- job_one_mm  in  1  job is a single MM, not a full ME
- job_tag  in  TAG_W  user tag returned with result
- job_a, job_e, job_m  in  M_SIZE  operands
- job_m_n  in  M_SIZE+2  modulus multiple
- job_m_prime  in  RADIX+SIZE_LOG+2  Montgomery constant
- en_pre_me, en_me, en_one_mm  out  1  single-cycle launch pulses to core
- num  out  4  slot id for current launch, values 0..3
- a, e, m  out  M_SIZE  registered operands to core
- m_n  out  M_SIZE+2  registered to core
- m_prime  out  RADIX+SIZE_LOG+2  registered to core
- z  in  M_SIZE  core result
- num_out  in  4  slot id of completing result
- done  in  1  single-cycle completion pulse
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts
- res_z  out  M_SIZE  result value
- res_tag  out  TAG_W  tag of completed job
- busy_slots  out  4  occupancy bitmap
- err  out  2  sticky: bit0 result overflow, bit1 spurious done

## Operation
- State machine: IDLE, PRE, WAIT, GO.
- IDLE: `job_ready` = 1 iff `busy_slots` != 4'hF.
  - On handshake, choose the lowest free slot `s`.
  - Register all operands, `job_one_mm` and `s`.
  - Write `tag_tbl[s]`, set `busy_slots[s]`, go to PRE.
- PRE, ordinary job: pulse `en_pre_me` with `num = s`, load wait counter with PRE_WAIT-1, go to WAIT.
- PRE, one_mm job: pulse `en_one_mm` instead and return to IDLE; no WAIT/GO.
- WAIT: decrement the counter; at 0 go to GO.
- GO: pulse `en_me` with `num = s`, return to IDLE.
- `job_ready` = 0 in PRE, WAIT and GO.
- Operand outputs hold their value from the accepting edge until the next accept; they never change between `en_pre_me` and `en_me`.
- On `done` with `k = num_out[1:0]`:
  - If `busy_slots[k]` is set: clear it.
    - If the result register is empty, or is being drained this cycle (`res_valid && res_ready`): load `res_z = z`, `res_tag = tag_tbl[k]`, `res_valid = 1`.
    - Otherwise: drop the result and set `err[0]`.
  - If `busy_slots[k]` is clear: set `err[1]`; nothing else changes.
- `res_valid` clears on `res_valid && res_ready` unless reloaded in the same cycle.
- Simultaneous accept and `done`:
  - The bitmap update combines clear(k) and set(s).
  - A slot freed this cycle cannot be chosen until the next cycle, because allocation uses the registered bitmap.
- `err` clears only on reset.

## Timing
- Reset values:
  - State IDLE.
  - All pulses, `job_ready`, `res_valid`, `busy_slots`, `err`: 0.
  - `num` 0; operands, `res_z`, `res_tag`: 0.
- `job_ready` rises the first cycle after reset deassertion.
- Accept at edge T:
  - `en_pre_me` high in cycle T+1.
  - `en_me` high in cycle T+1+PRE_WAIT+1.
  - `job_ready` high again the cycle after GO.
  - Minimum accept-to-accept spacing is PRE_WAIT+3 cycles; a one_mm job gives 2 cycles.
- `done` at edge T: `res_valid` is high from T+1 and `busy_slots[k]` is clear from T+1.
- Reset mid-launch abandons the job, clears all slots, and drops any held result.

## Structure
- Shared package `me_pkg`:
  - Slot count (4) and slot id width.
  - State enum.
  - Localparams for the m_n and m_prime widths.
- Sub-module `slot_alloc`: combinational lowest-free priority encoder with a `full` output, over the 4-bit bitmap.
- Tag table: a 4×TAG_W register array inside the top.

## Test plan
- Reset, then one job (tag 0x11, PRE_WAIT=4) -> `en_pre_me` at T+1 with num=0, `en_me` at T+6 with num=0; `busy_slots` = 0001.
- Four back-to-back jobs, then a fifth offered -> slots 0,1,2,3 in order; `job_ready` low with `busy_slots` = 1111 until a `done` arrives.
- `done` with num_out=2, z=0xABC -> `res_valid` next cycle, res_z=0xABC, res_tag = slot 2 tag; `busy_slots[2]` clears.
- `res_ready`=0 and two `done` pulses -> first result held, second dropped, err=01; both slots free.
- `done` for an empty slot -> err[1]=1, `busy_slots` unchanged.
- A one_mm job -> `en_one_mm` single pulse at T+1, no `en_pre_me`/`en_me`; `job_ready` high at T+2.
